// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds the controller state encoding, address-field widths and a helper
// that selects one 32-bit word out of a 256-bit cache line.
package dcache_pkg;

    localparam int LINES  = 32;
    localparam int TAG_W  = 22;
    localparam int IDX_W  = 5;
    localparam int LINE_W = 256;
    localparam int OFF_W  = 5;
    localparam int WORD_W = 32;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        FILL      = 2'd3
    } state_e;

    // Word 'sel' of a line; word 0 occupies bits [31:0].
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                     input logic [SEL_W-1:0]  sel);
        return line[{sel, 5'b00000} +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/state array and data array for the data cache.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset (clears valid/dirty)
//   rd_idx                read index; rd_valid/rd_dirty/rd_tag/rd_line are combinational
//   line_we               full-line write: stores wr_tag/wr_line, valid=1, dirty=0
//   word_we               32-bit word write of wr_word at wr_sel, sets dirty
//   wr_idx                index used by both write types
module dcache_sram
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              line_we,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [WORD_W-1:0] wr_word
);

    logic [LINES-1:0]  valid_r;
    logic [LINES-1:0]  dirty_r;
    logic [TAG_W-1:0]  tag_mem_r  [LINES];
    logic [LINE_W-1:0] data_mem_r [LINES];

    assign rd_valid = valid_r[rd_idx];
    assign rd_dirty = dirty_r[rd_idx];
    assign rd_tag   = tag_mem_r[rd_idx];
    assign rd_line  = data_mem_r[rd_idx];

    // Line state bits: only these need reset, array contents are don't-care until valid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_r <= {LINES{1'b0}};
            dirty_r <= {LINES{1'b0}};
        end else if (line_we) begin
            valid_r[wr_idx] <= 1'b1;
            dirty_r[wr_idx] <= 1'b0;
        end else if (word_we) begin
            dirty_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage: full-line fill or single-word store.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_mem_r[wr_idx]  <= wr_tag;
            data_mem_r[wr_idx] <= wr_line;
        end else if (word_we) begin
            data_mem_r[wr_idx][{wr_sel, 5'b00000} +: WORD_W] <= wr_word;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Ports:
//   clk_i, rst_i                          clock, asynchronous active-low reset
//   p1_addr_i/p1_data_i                   CPU byte address and store data
//   p1_memread_i/p1_memwrite_i            load / store request (store wins)
//   p1_data_o                             load data, combinational on a hit, else 0
//   p1_stall_o                            memstall to the pipeline registers
//   mem_addr_o/mem_data_o                 line address and victim line to memory
//   mem_enable_o/mem_write_o              memory request valid, 1=writeback 0=refill
//   mem_data_i/mem_ack_i                  refill line and one-cycle completion pulse
module dcache_controller
    import dcache_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [31:0]   p1_addr_i,
    input  logic [31:0]   p1_data_i,
    input  logic          p1_memread_i,
    input  logic          p1_memwrite_i,
    output logic [31:0]   p1_data_o,
    output logic          p1_stall_o,
    output logic [31:0]   mem_addr_o,
    output logic [255:0]  mem_data_o,
    output logic          mem_enable_o,
    output logic          mem_write_o,
    input  logic [255:0]  mem_data_i,
    input  logic          mem_ack_i
);

    state_e            state_r;
    logic              mem_enable_r;
    logic              mem_write_r;
    logic [31:0]       mem_addr_r;
    logic [LINE_W-1:0] mem_data_r;
    logic [LINE_W-1:0] fill_line_r;

    logic              req_s;
    logic              hit_s;
    logic [TAG_W-1:0]  req_tag_s;
    logic [IDX_W-1:0]  idx_s;
    logic [SEL_W-1:0]  sel_s;
    logic              rd_valid_s;
    logic              rd_dirty_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [LINE_W-1:0] rd_line_s;
    logic              line_we_s;
    logic              word_we_s;
    logic              unused_addr_s;

    assign req_tag_s     = p1_addr_i[31:10];
    assign idx_s         = p1_addr_i[9:5];
    assign sel_s         = p1_addr_i[4:2];
    assign unused_addr_s = ^p1_addr_i[1:0];

    assign req_s = p1_memread_i | p1_memwrite_i;
    assign hit_s = rd_valid_s & (rd_tag_s == req_tag_s);

    // Stores only commit from IDLE; the request is held stable across a miss,
    // so after FILL the same store retires here as an ordinary hit.
    assign word_we_s = (state_r == IDLE) & req_s & hit_s & p1_memwrite_i;
    assign line_we_s = (state_r == FILL);

    dcache_sram u_sram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_idx   (idx_s),
        .rd_valid (rd_valid_s),
        .rd_dirty (rd_dirty_s),
        .rd_tag   (rd_tag_s),
        .rd_line  (rd_line_s),
        .line_we  (line_we_s),
        .word_we  (word_we_s),
        .wr_idx   (idx_s),
        .wr_tag   (req_tag_s),
        .wr_line  (fill_line_r),
        .wr_sel   (sel_s),
        .wr_word  (p1_data_i)
    );

    // CPU-side outputs; stall is masked during reset so the pipeline is released at once.
    always_comb begin
        p1_data_o  = 32'd0;
        p1_stall_o = 1'b0;
        if (hit_s) begin
            p1_data_o = line_word(rd_line_s, sel_s);
        end else begin
            p1_data_o = 32'd0;
        end
        if (rst_i) begin
            p1_stall_o = (state_r != IDLE) | (req_s & ~hit_s);
        end else begin
            p1_stall_o = 1'b0;
        end
    end

    assign mem_enable_o = mem_enable_r;
    assign mem_write_o  = mem_write_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;

    // Miss-handling FSM with registered memory-side request outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= IDLE;
            mem_enable_r <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_data_r   <= {LINE_W{1'b0}};
            fill_line_r  <= {LINE_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && !hit_s) begin
                        if (rd_valid_s && rd_dirty_s) begin
                            state_r      <= WRITEBACK;
                            mem_enable_r <= 1'b1;
                            mem_write_r  <= 1'b1;
                            mem_addr_r   <= {rd_tag_s, idx_s, 5'b00000};
                            mem_data_r   <= rd_line_s;
                        end else begin
                            state_r      <= REFILL;
                            mem_enable_r <= 1'b1;
                            mem_write_r  <= 1'b0;
                            mem_addr_r   <= {req_tag_s, idx_s, 5'b00000};
                            mem_data_r   <= {LINE_W{1'b0}};
                        end
                    end
                end
                WRITEBACK: begin
                    // Enable stays high straight into the refill request.
                    if (mem_ack_i) begin
                        state_r     <= REFILL;
                        mem_write_r <= 1'b0;
                        mem_addr_r  <= {req_tag_s, idx_s, 5'b00000};
                        mem_data_r  <= {LINE_W{1'b0}};
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_r      <= FILL;
                        fill_line_r  <= mem_data_i;
                        mem_enable_r <= 1'b0;
                        mem_write_r  <= 1'b0;
                        mem_addr_r   <= 32'd0;
                        mem_data_r   <= {LINE_W{1'b0}};
                    end
                end
                FILL: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    mem_enable_r <= 1'b0;
                    mem_write_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: a high-level cache/memory model
// predicts every CPU completion and every memory transaction; independent
// monitor processes compare them when the DUT presents them.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         rd;
    logic         wr;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_rdata;
    logic         dev_ack;
    logic         spur_ack;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .p1_addr_i     (addr),
        .p1_data_i     (wdata),
        .p1_memread_i  (rd),
        .p1_memwrite_i (wr),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_data_i    (mem_rdata),
        .mem_ack_i     (dev_ack | spur_ack)
    );

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_txn_t;

    typedef struct packed {
        logic         is_load;
        logic [31:0]  data;
        logic [31:0]  stall;
    } resp_t;

    mem_txn_t mem_q[$];
    resp_t    resp_q[$];

    int vectors = 0;
    int errors  = 0;
    int lat     = 1;
    int stall_cnt = 0;
    int dev_cnt   = 0;

    // Reference model: cache contents as plain arrays, memory as a sparse map.
    logic               ref_valid [32];
    logic               ref_dirty [32];
    logic [21:0]        ref_tag   [32];
    logic [255:0]       ref_line  [32];
    logic [255:0]       ref_mem   [logic [26:0]];
    logic [255:0]       dev_mem   [logic [26:0]];

    function automatic logic [255:0] init_line(input logic [26:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = ({la, 5'b00000} + 32'(i * 4)) ^ 32'h5A5A_1234;
        end
        return l;
    endfunction

    function automatic logic [255:0] ref_read(input logic [26:0] la);
        if (ref_mem.exists(la)) return ref_mem[la];
        return init_line(la);
    endfunction

    function automatic logic [255:0] dev_read(input logic [26:0] la);
        if (dev_mem.exists(la)) return dev_mem[la];
        return init_line(la);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 32; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = 22'd0;
            ref_line[i]  = 256'd0;
        end
    endtask

    // Predicts one access, pushes expectations, then drives it until completion.
    task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] d);
        int idx;
        int w;
        logic [21:0] tg;
        resp_t r;
        mem_txn_t t;
        bit done;
        idx = int'(a[9:5]);
        w   = int'(a[4:2]);
        tg  = a[31:10];
        r.stall = 32'd0;
        r.is_load = ~st;
        r.data = 32'd0;
        if (!(ref_valid[idx] && ref_tag[idx] == tg)) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                t.wr = 1'b1;
                t.addr = {ref_tag[idx], a[9:5], 5'b00000};
                t.data = ref_line[idx];
                mem_q.push_back(t);
                ref_mem[{ref_tag[idx], a[9:5]}] = ref_line[idx];
                r.stall += 32'(lat);
            end
            t.wr = 1'b0;
            t.addr = {tg, a[9:5], 5'b00000};
            t.data = 256'd0;
            mem_q.push_back(t);
            ref_line[idx]  = ref_read(a[31:5]);
            ref_valid[idx] = 1'b1;
            ref_dirty[idx] = 1'b0;
            ref_tag[idx]   = tg;
            r.stall += 32'(lat + 2);
        end
        if (st) begin
            ref_line[idx][w*32 +: 32] = d;
            ref_dirty[idx] = 1'b1;
        end else begin
            r.data = ref_line[idx][w*32 +: 32];
        end
        resp_q.push_back(r);

        addr = a; wdata = d; rd = ~st; wr = st;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (!p1_stall_o) done = 1'b1;
        end
        if (!done) begin
            errors++;
            $display("FAIL timeout: stall still high at addr %h", a);
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    // CPU-side monitor: counts stall cycles and checks each completion.
    always @(negedge clk) begin
        resp_t r;
        if (rst_i && (rd || wr)) begin
            if (p1_stall_o) begin
                stall_cnt++;
            end else begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_completion", 256'd1, 256'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk("stall_cycles", 256'(stall_cnt), 256'(r.stall));
                    if (r.is_load) chk("load_data", 256'(p1_data_o), 256'(r.data));
                end
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    // Memory device: acks on the lat-th cycle of a request and checks it against the model.
    always @(posedge clk) begin
        mem_txn_t t;
        #1;
        if (!mem_enable_o || !rst_i) begin
            dev_cnt = 0;
            dev_ack = 1'b0;
        end else begin
            dev_cnt++;
            if (dev_cnt >= lat) begin
                dev_ack = 1'b1;
                dev_cnt = 0;
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_req", 256'd1, 256'd0);
                end else begin
                    t = mem_q.pop_front();
                    chk("mem_write", 256'(mem_write_o), 256'(t.wr));
                    chk("mem_addr", 256'(mem_addr_o), 256'(t.addr));
                    if (t.wr) chk("wb_data", mem_data_o, t.data);
                end
                if (mem_write_o) dev_mem[mem_addr_o[31:5]] = mem_data_o;
                else mem_rdata = dev_read(mem_addr_o[31:5]);
            end else begin
                dev_ack = 1'b0;
            end
        end
    end

    initial begin
        logic [255:0] l;
        logic [31:0]  a;
        rst_i = 1'b0; addr = 32'd0; wdata = 32'd0; rd = 1'b0; wr = 1'b0;
        spur_ack = 1'b0; dev_ack = 1'b0; mem_rdata = 256'd0;
        ref_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_enable", 256'(mem_enable_o), 256'd0);
        chk("rst_mem_write",  256'(mem_write_o),  256'd0);
        chk("rst_mem_addr",   256'(mem_addr_o),   256'd0);
        chk("rst_mem_data",   mem_data_o,         256'd0);
        chk("rst_p1_data",    256'(p1_data_o),    256'd0);
        chk("rst_stall",      256'(p1_stall_o),   256'd0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;

        // Cold load, 10-cycle memory, line 0x400 word1 = DEADBEEF.
        l = init_line(27'h20);
        l[63:32] = 32'hDEAD_BEEF;
        ref_mem[27'h20] = l;
        dev_mem[27'h20] = l;
        lat = 10;
        issue(1'b0, 32'h0000_0404, 32'd0);
        issue(1'b1, 32'h0000_0404, 32'h1234_5678);
        issue(1'b0, 32'h0000_0404, 32'd0);

        // Spurious ack during a hit must be ignored.
        spur_ack = 1'b1;
        issue(1'b0, 32'h0000_0404, 32'd0);
        spur_ack = 1'b0;
        issue(1'b0, 32'h0000_0400, 32'd0);

        // Dirty conflict miss: writeback 0x400 then refill 0x800.
        lat = 4;
        issue(1'b0, 32'h0000_0804, 32'd0);

        // Zero-wait memory clean miss: 3 stall cycles.
        lat = 1;
        issue(1'b0, 32'h0000_0C24, 32'd0);

        // Reset in the middle of a refill.
        lat = 20;
        addr = 32'h0001_03E4; rd = 1'b1;
        repeat (5) @(negedge clk);
        chk("refill_stall", 256'(p1_stall_o), 256'd1);
        chk("refill_enable", 256'(mem_enable_o), 256'd1);
        chk("refill_addr", 256'(mem_addr_o), 256'h0001_03E0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        #1;
        chk("midrst_enable", 256'(mem_enable_o), 256'd0);
        chk("midrst_stall",  256'(p1_stall_o),   256'd0);
        chk("midrst_write",  256'(mem_write_o),  256'd0);
        rd = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        ref_reset();
        lat = 3;
        issue(1'b0, 32'h0001_03E4, 32'd0);
        issue(1'b0, 32'h0000_0404, 32'd0);

        // Randomized traffic over a few tags per index to exercise conflicts.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(1, 5));
            a = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            issue(1'($urandom_range(0, 1)), a, $urandom);
        end

        repeat (5) @(posedge clk);
        chk("mem_q_drained",  256'(mem_q.size()),  256'd0);
        chk("resp_q_drained", 256'(resp_q.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

- Direct-mapped, write-back, write-allocate data cache controller.
- Services load/store requests from the MEM stage (address, store data and mem read/write controls presented by the EX/MEM register).
- Produces the memstall signal that freezes the pipeline registers on a miss.
- Moves 256-bit lines to and from the external data memory over an enable/ack handshake.

## Interface
- LINES, 32: number of cache lines (index width = log2(LINES) = 5).
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous reset, active-low.
- p1_addr_i  in  32  CPU byte address (word-aligned; bits [1:0] ignored).
- p1_data_i  in  32  CPU store data.
- p1_memread_i  in  1  load request.
- p1_memwrite_i  in  1  store request; takes priority if both are asserted.
- p1_data_o  out  32  load data, valid in the same cycle as a hit.
- p1_stall_o  out  1  memstall to the pipeline registers.
- mem_addr_o  out  32  line address to memory, bits [4:0] = 0.
- mem_data_o  out  256  victim line for writeback.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = writeback, 0 = refill read.
- mem_data_i  in  256  refill line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

## Operation
- Address split:
  - tag = addr[31:10] (22 bits)
  - index = addr[9:5]
  - word = addr[4:2]
- Per-line storage: valid, dirty, 22-bit tag, 256-bit data.
- req = p1_memread_i | p1_memwrite_i.
- hit = valid[index] & (tag[index] == addr tag).
- FSM states: IDLE, WRITEBACK, REFILL, FILL.
  - IDLE:
    - On req & hit: a load returns word[word] combinationally; a store writes that 32-bit word and sets dirty at the next posedge.
    - On req & ~hit & dirty: go to WRITEBACK.
    - On req & ~hit & ~dirty (or ~valid): go to REFILL.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={old tag, index, 5'b0}, mem_data_o = victim line; on mem_ack_i go to REFILL.
  - REFILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}; on mem_ack_i capture mem_data_i and go to FILL.
  - FILL: write the captured line, tag, valid=1, dirty=0; go to IDLE. The access then hits on the next cycle and completes as a normal hit.
- p1_stall_o = (state != IDLE) | (req & ~hit).
  - Drops in the same cycle the post-fill hit is seen.
  - The pipeline keeps the request stable while stalled.
- mem_ack_i is ignored outside WRITEBACK/REFILL.
- mem_enable_o stays high, and the address and data stay stable, until the ack cycle. It drops in the cycle after ack.

## Timing
- Hit: 0 stall cycles; load data is combinational from the array.
- Clean miss: stall = 1 (IDLE detect) + refill latency (cycles to ack) + 1 (FILL).
- Dirty miss: adds the writeback latency before REFILL.
- Reset (rst_i low, asynchronous):
  - All valid and dirty bits = 0, state = IDLE.
  - mem_enable_o = 0, mem_write_o = 0.
  - mem_addr_o = 0, mem_data_o = 0, p1_data_o = 0 while no hit.
  - p1_stall_o = 0 while req is low.
- Reset mid-WRITEBACK/REFILL: the transaction is abandoned and mem_enable_o drops immediately. Dirty data is lost; the memory model must tolerate the abandoned request.
- Ack arriving in the same cycle enable first rises is legal (zero-wait memory).
- Request deasserted while stalled is illegal; behaviour is unspecified.

## Structure
- Shared package holds:
  - state encodings (IDLE=2'd0, WRITEBACK=2'd1, REFILL=2'd2, FILL=2'd3)
  - TAG_W=22, IDX_W=5, LINE_W=256, OFF_W=5
- One sub-module, dcache_sram: LINES-entry tag array (tag + valid + dirty) and data array.
  - Asynchronous read, synchronous write.
  - Write port carries either a full-line write or a 32-bit word write with word select.
- The controller holds the FSM, hit logic, the refill capture register and the output muxing.

## Test plan
- Cold load to 0x0000_0404 → stall asserted; REFILL mem_addr_o=0x0000_0400; ack after 10 cycles with line whose word1=0xDEAD_BEEF → p1_data_o=0xDEAD_BEEF, stall drops 12 cycles after request.
- Store 0x1234_5678 to 0x0000_0404 after fill → no stall; following load at the same address returns 0x1234_5678 with 0 stall.
- Load to 0x0000_0804 (same index, new tag) after the dirty store → WRITEBACK to 0x0000_0400 with word1=0x1234_5678, then REFILL 0x0000_0800.
- Zero-wait memory (ack tied to enable) on a clean miss → stall lasts exactly 3 cycles.
- rst_i low during REFILL → mem_enable_o=0 and p1_stall_o=0 immediately; the same address then misses again after reset.
- Spurious mem_ack_i in IDLE while a hit is in progress → no state change, hit data unaffected.
